// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-port bundle. The arbiter uses the slave modport;
// the requesters and the memory sit on the master side.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_f;
    logic        stall_m;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack,
               mem_cs, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
               mem_cs, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

endinterface

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Starvation counter for IF under continuous DM traffic; compiled only when
// ARB_FAIR_EN is defined.
`ifdef ARB_FAIR_EN
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic force_if
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign force_if = (cnt_q == LIMIT);

    // Next count: clear on IF grant, count DM grants that bypass a waiting IF
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (inc && !force_if) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the IF and MEM stages with data priority and a
// fixed-latency access FSM. Define ARB_FAIR_EN to bound IF starvation.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYC   = 2,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC);

    state_t           state_q,    state_d;
    gnt_t             gnt_q,      gnt_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [31:0]      addr_q,     addr_d;
    logic             we_q,       we_d;
    logic [31:0]      wdata_q,    wdata_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      dm_rdata_q, dm_rdata_d;
    logic             if_ack_q,   if_ack_d;
    logic             dm_ack_q,   dm_ack_d;
    logic             force_if_s;

`ifdef ARB_FAIR_EN
    logic inc_s;
    logic clr_s;

    assign inc_s = (state_q == ST_IDLE) && (state_d == ST_BUSY) &&
                   (gnt_d == GNT_DM) && bus.if_req;
    assign clr_s = (state_q == ST_IDLE) && (state_d == ST_BUSY) &&
                   (gnt_d == GNT_IF);

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc_s),
        .clr      (clr_s),
        .force_if (force_if_s)
    );
`else
    // Always 0 over the legal STARVE_MAX range: strict data priority.
    assign force_if_s = (STARVE_MAX == 0);
`endif

    // Arbitration in IDLE, wait countdown in BUSY, result capture on the last BUSY cycle
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.dm_req && !(force_if_s && bus.if_req)) begin
                    state_d = ST_BUSY;
                    gnt_d   = GNT_DM;
                    cnt_d   = WAIT_LD;
                    addr_d  = bus.dm_addr;
                    we_d    = bus.dm_we;
                    wdata_d = bus.dm_wdata;
                end else if (bus.if_req) begin
                    state_d = ST_BUSY;
                    gnt_d   = GNT_IF;
                    cnt_d   = WAIT_LD;
                    addr_d  = bus.if_addr;
                    we_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                    if (gnt_q == GNT_DM) begin
                        dm_ack_d = 1'b1;
                        if (!we_q) begin
                            dm_rdata_d = bus.mem_rdata;
                        end else begin
                            dm_rdata_d = dm_rdata_q;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= GNT_IF;
            cnt_q      <= CNT_ZERO;
            addr_q     <= 32'h0000_0000;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0000_0000;
            if_rdata_q <= 32'h0000_0000;
            dm_rdata_q <= 32'h0000_0000;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
        end
    end

    assign bus.mem_cs    = (state_q == ST_BUSY);
    assign bus.mem_we    = (state_q == ST_BUSY) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.stall_f   = bus.if_req & ~if_ack_q;
    assign bus.stall_m   = bus.dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline model checked every cycle,
// plus directed literal checks (WAIT_CYC=2 main instance, WAIT_CYC=0 second instance).
module tb_mem_port_arbiter;

    localparam int W  = 2;
    localparam int SM = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_port_arbiter_if bus ();
    mem_port_arbiter_if bus0 ();

    mem_port_arbiter #(.WAIT_CYC(W), .STARVE_MAX(SM)) u_dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
    );

    mem_port_arbiter #(.WAIT_CYC(0), .STARVE_MAX(SM)) u_dut0 (
        .clk (clk), .rst (rst), .bus (bus0.slave)
    );

    assign bus0.mem_rdata = bus0.mem_addr + 32'h0000_1000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0000_0013;
        else return a ^ 32'h5A5A_0000;
    endfunction

    // Model: each grant occupies BUSY cycles st..st+W and acks in st+W+1.
    initial begin : model
        int          c;
        bit          act, m_dm, m_we, busy, ack, frc;
        logic [31:0] m_addr, m_wd, e_ifr, e_dmr;
        int          st, starve;
        c = 0; act = 1'b0; m_dm = 1'b0; m_we = 1'b0; st = 0; starve = 0;
        m_addr = 32'h0; m_wd = 32'h0; e_ifr = 32'h0; e_dmr = 32'h0;
        forever begin
            @(negedge clk);
            c++;
            if (rst) begin
                act = 1'b0; m_addr = 32'h0; e_ifr = 32'h0; e_dmr = 32'h0; starve = 0;
                chk("rst_cs", {31'd0, bus.mem_cs}, 32'd0);
                chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
                chk("rst_addr", bus.mem_addr, 32'h0);
                chk("rst_wdata", bus.mem_wdata, 32'h0);
                chk("rst_acks", {30'd0, bus.if_ack, bus.dm_ack}, 32'd0);
                chk("rst_ifr", bus.if_rdata, 32'h0);
                chk("rst_dmr", bus.dm_rdata, 32'h0);
                bus.mem_rdata = 32'hBAD0_BAD0;
            end else begin
                busy = act && (c >= st) && (c <= st + W);
                ack  = act && (c == st + W + 1);
                if (ack && !m_dm) e_ifr = rdata_of(m_addr);
                if (ack && m_dm && !m_we) e_dmr = rdata_of(m_addr);
                chk("mem_cs", {31'd0, bus.mem_cs}, {31'd0, busy});
                chk("mem_we", {31'd0, bus.mem_we}, {31'd0, busy && m_we});
                chk("mem_addr", bus.mem_addr, m_addr);
                if (busy && m_we) chk("mem_wdata", bus.mem_wdata, m_wd);
                chk("if_ack", {31'd0, bus.if_ack}, {31'd0, ack && !m_dm});
                chk("dm_ack", {31'd0, bus.dm_ack}, {31'd0, ack && m_dm});
                chk("if_rdata", bus.if_rdata, e_ifr);
                chk("dm_rdata", bus.dm_rdata, e_dmr);
                chk("stall_f", {31'd0, bus.stall_f}, {31'd0, bus.if_req && !(ack && !m_dm)});
                chk("stall_m", {31'd0, bus.stall_m}, {31'd0, bus.dm_req && !(ack && m_dm)});
                bus.mem_rdata = (busy && c == st + W) ? rdata_of(m_addr) : 32'hBAD0_BAD0;
                if (!busy) begin
                    frc = 1'b0;
`ifdef ARB_FAIR_EN
                    frc = (starve == SM) && bus.if_req;
`endif
                    if (bus.dm_req && !frc) begin
                        act = 1'b1; m_dm = 1'b1; m_we = bus.dm_we; m_addr = bus.dm_addr;
                        m_wd = bus.dm_wdata; st = c + 1;
                        if (bus.if_req) starve++;
                    end else if (bus.if_req) begin
                        act = 1'b1; m_dm = 1'b0; m_we = 1'b0; m_addr = bus.if_addr;
                        st = c + 1; starve = 0;
                    end
                end
            end
        end
    end

    typedef struct {
        bit          di;
        logic [31:0] ia;
        bit          dd;
        bit          we;
        logic [31:0] da;
        logic [31:0] dw;
    } vec_t;

    // Raise the requested transactions and drop each req in its own ack cycle.
    task automatic serve(input vec_t v);
        bit ip, dp;
        int n;
        ip = v.di; dp = v.dd; n = 0;
        @(posedge clk); #1;
        bus.if_req = v.di; bus.if_addr = v.ia;
        bus.dm_req = v.dd; bus.dm_we = v.we; bus.dm_addr = v.da; bus.dm_wdata = v.dw;
        while ((ip || dp) && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus.if_ack) begin ip = 1'b0; bus.if_req = 1'b0; end
            if (bus.dm_ack) begin dp = 1'b0; bus.dm_req = 1'b0; end
        end
        total++;
        if (ip || dp) begin
            bad++;
            $display("FAIL serve_timeout: pending if=%0d dm=%0d want none", ip, dp);
            bus.if_req = 1'b0; bus.dm_req = 1'b0;
        end
    endtask

    vec_t vecs[5];

    initial begin : stim
        total = 0; bad = 0;
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0;
        bus0.if_req = 1'b0; bus0.if_addr = 32'h0; bus0.dm_req = 1'b0; bus0.dm_we = 1'b0;
        bus0.dm_addr = 32'h0; bus0.dm_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_cs", {31'd0, bus.mem_cs}, 32'd0);
        chk("reset_ifr", bus.if_rdata, 32'h0);

        // Single fetch: BUSY cycles 1..3, ack in cycle 4
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
        @(negedge clk);
        chk("t1_stall0", {31'd0, bus.stall_f}, 32'd1);
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            if (n == 4) bus.if_req = 1'b0;
            @(negedge clk);
            chk("t1_cs", {31'd0, bus.mem_cs}, (n <= 3) ? 32'd1 : 32'd0);
            chk("t1_ack", {31'd0, bus.if_ack}, (n == 4) ? 32'd1 : 32'd0);
            if (n <= 3) chk("t1_stall", {31'd0, bus.stall_f}, 32'd1);
            if (n == 4) chk("t1_rdata", bus.if_rdata, 32'h0000_0013);
        end

        // Simultaneous IF and DM load: DM acks in cycle 4, IF in cycle 8
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0104;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_0200;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (bus.dm_ack) bus.dm_req = 1'b0;
            if (bus.if_ack) bus.if_req = 1'b0;
            @(negedge clk);
            chk("t2_dm_ack", {31'd0, bus.dm_ack}, (n == 4) ? 32'd1 : 32'd0);
            chk("t2_if_ack", {31'd0, bus.if_ack}, (n == 8) ? 32'd1 : 32'd0);
            chk("t2_cs", {31'd0, bus.mem_cs}, (n != 4 && n != 8) ? 32'd1 : 32'd0);
            if (n == 4) chk("t2_dmr", bus.dm_rdata, 32'h5A5A_0200);
            if (n == 8) chk("t2_ifr", bus.if_rdata, 32'h5A5A_0104);
        end

        // Store: stable write port for all BUSY cycles, load data untouched
        @(posedge clk); #1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h0000_0300;
        bus.dm_wdata = 32'hDEAD_BEEF;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            if (n == 4) bus.dm_req = 1'b0;
            @(negedge clk);
            if (n <= 3) begin
                chk("t3_we", {31'd0, bus.mem_we}, 32'd1);
                chk("t3_addr", bus.mem_addr, 32'h0000_0300);
                chk("t3_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            end else begin
                chk("t3_ack", {31'd0, bus.dm_ack}, 32'd1);
                chk("t3_dmr", bus.dm_rdata, 32'h5A5A_0200);
            end
        end

        // Directed back-to-back mixes checked by the model
        vecs[0] = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 32'h0000_0014, 1'b1, 1'b1, 32'h0000_0040, 32'h1111_2222};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0040, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_0018, 1'b1, 1'b0, 32'h0000_0044, 32'h0};
        vecs[4] = '{1'b1, 32'h0000_001C, 1'b1, 1'b1, 32'h0000_0048, 32'hCAFE_F00D};
        foreach (vecs[i]) serve(vecs[i]);

        // Reset during the second BUSY cycle aborts the fetch
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0400;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("t4_cs", {31'd0, bus.mem_cs}, 32'd0);
        chk("t4_addr", bus.mem_addr, 32'h0);
        chk("t4_ifr", bus.if_rdata, 32'h0);
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("t4_no_ack", {30'd0, bus.if_ack, bus.dm_ack}, 32'd0);
            chk("t4_idle", {31'd0, bus.mem_cs}, 32'd0);
        end

`ifdef ARB_FAIR_EN
        begin
            int got[$];
            int n;
            n = 0;
            @(posedge clk); #1;
            bus.if_req = 1'b1; bus.if_addr = 32'h0000_0500;
            bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_0600;
            while (got.size() < 6 && n < 100) begin
                @(posedge clk); #1;
                n++;
                if (bus.if_ack) got.push_back(0);
                if (bus.dm_ack) got.push_back(1);
            end
            bus.if_req = 1'b0; bus.dm_req = 1'b0;
            total++;
            if (got.size() < 6) begin
                bad++;
                $display("FAIL fair_timeout: grants=%0d want 6", got.size());
            end else begin
                for (int i = 0; i < 6; i++)
                    chk("fair_order", got[i], (i % 3 == 2) ? 32'd0 : 32'd1);
            end
        end
`endif

        // WAIT_CYC=0, fetch held high: ack every 2nd cycle, next address each time
        @(posedge clk); #1;
        bus0.if_req = 1'b1; bus0.if_addr = 32'h0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (bus0.if_ack) bus0.if_addr = bus0.if_addr + 32'd4;
            @(negedge clk);
            chk("w0_ack", {31'd0, bus0.if_ack}, (n % 2 == 0) ? 32'd1 : 32'd0);
            chk("w0_stall", {31'd0, bus0.stall_f}, (n % 2 == 0) ? 32'd0 : 32'd1);
            if (n % 2 == 0) chk("w0_rdata", bus0.if_rdata, 32'h0000_1000 + 32'(4 * (n / 2 - 1)));
        end
        bus0.if_req = 1'b0;

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
